// File: rtl/alsu_pkg.sv
// alsu_pkg: shared constants for the ALSU command driver.
// Opcodes, flag bit positions and driver FSM encoding.
package alsu_pkg;

  localparam logic [2:0] OP_AND    = 3'd0;
  localparam logic [2:0] OP_XOR    = 3'd1;
  localparam logic [2:0] OP_ADD    = 3'd2;
  localparam logic [2:0] OP_MUL    = 3'd3;
  localparam logic [2:0] OP_SHIFT  = 3'd4;
  localparam logic [2:0] OP_ROTATE = 3'd5;

  localparam int F_CIN    = 6;
  localparam int F_SERIAL = 5;
  localparam int F_RED_A  = 4;
  localparam int F_RED_B  = 3;
  localparam int F_BYP_A  = 2;
  localparam int F_BYP_B  = 1;
  localparam int F_DIR    = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/alsu_driver.sv
// alsu_driver: issues one ALSU operation per command handshake,
// waits out the ALSU latency and returns the captured result.
module alsu_driver
  import alsu_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_a,
  input  logic [2:0]  cmd_b,
  input  logic [2:0]  cmd_opcode,
  input  logic [6:0]  cmd_flags,
  output logic [2:0]  alsu_a,
  output logic [2:0]  alsu_b,
  output logic [2:0]  alsu_opcode,
  output logic [6:0]  alsu_flags,
  input  logic [5:0]  alsu_out,
  input  logic [15:0] alsu_leds,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [5:0]  rsp_out,
  output logic        rsp_err,
  output logic [15:0] done_count,
  output logic [7:0]  err_count
);

  localparam int CW = $clog2(LATENCY + 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          acc;
  logic          cap;
  logic          hs;

  // Next state plus accept / capture / handshake strobes
  always_comb begin
    state_nxt = state;
    acc       = 1'b0;
    cap       = 1'b0;
    hs        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          acc       = 1'b1;
          state_nxt = ST_DRIVE;
        end
      end
      ST_DRIVE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (cnt == CW'(1)) begin
          cap       = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          hs        = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, latency counter and registered ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cmd_ready <= 1'b0;
    end else begin
      state     <= state_nxt;
      cmd_ready <= (state_nxt == ST_IDLE);
      if (state == ST_DRIVE)
        cnt <= CW'(LATENCY);
      else if (state == ST_WAIT)
        cnt <= cnt - CW'(1);
    end
  end

  // One-cycle command pulse toward the ALSU, parked at zero otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alsu_a      <= '0;
      alsu_b      <= '0;
      alsu_opcode <= '0;
      alsu_flags  <= '0;
    end else if (acc) begin
      alsu_a      <= cmd_a;
      alsu_b      <= cmd_b;
      alsu_opcode <= cmd_opcode;
      alsu_flags  <= cmd_flags;
    end else begin
      alsu_a      <= '0;
      alsu_b      <= '0;
      alsu_opcode <= '0;
      alsu_flags  <= '0;
    end
  end

  // Result capture and response handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_out   <= '0;
      rsp_err   <= 1'b0;
    end else if (cap) begin
      rsp_valid <= 1'b1;
      rsp_out   <= alsu_out;
      rsp_err   <= |alsu_leds;
    end else if (hs) begin
      rsp_valid <= 1'b0;
    end
  end

  // Completion counter wraps, error counter saturates
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_count <= '0;
      err_count  <= '0;
    end else if (hs) begin
      done_count <= done_count + 16'd1;
      if (rsp_err && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_alsu_driver.sv
// tb_alsu_driver: directed + random checks of alsu_driver
// against a behavioural ALSU and response scoreboard.
module tb_alsu_driver;
  import alsu_pkg::*;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_a;
  logic [2:0]  cmd_b;
  logic [2:0]  cmd_opcode;
  logic [6:0]  cmd_flags;
  logic [2:0]  alsu_a;
  logic [2:0]  alsu_b;
  logic [2:0]  alsu_opcode;
  logic [6:0]  alsu_flags;
  logic [5:0]  alsu_out;
  logic [15:0] alsu_leds;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [5:0]  rsp_out;
  logic        rsp_err;
  logic [15:0] done_count;
  logic [7:0]  err_count;

  int ncmp = 0;
  int nfail = 0;
  int exp_done = 0;
  int exp_err = 0;

  always #5 clk = ~clk;

  alsu_driver #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_opcode(cmd_opcode), .cmd_flags(cmd_flags),
    .alsu_a(alsu_a), .alsu_b(alsu_b),
    .alsu_opcode(alsu_opcode), .alsu_flags(alsu_flags),
    .alsu_out(alsu_out), .alsu_leds(alsu_leds),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out(rsp_out), .rsp_err(rsp_err),
    .done_count(done_count), .err_count(err_count)
  );

  // Behavioural ALSU: returns {error, out}
  function automatic logic [6:0] alsu_f(
    input logic [2:0] a, input logic [2:0] b,
    input logic [2:0] op, input logic [6:0] f);
    logic [5:0] o;
    logic       e;
    logic       ra, rb;
    ra = f[F_RED_A];
    rb = f[F_RED_B];
    e = (op > OP_ROTATE) ||
        ((ra || rb) && (op != OP_AND) && (op != OP_XOR));
    o = '0;
    if (e)
      o = '0;
    else if (f[F_BYP_A])
      o = {3'b0, a};
    else if (f[F_BYP_B])
      o = {3'b0, b};
    else begin
      case (op)
        OP_AND: o = ra ? {5'b0, &a} : rb ? {5'b0, &b} : {3'b0, a & b};
        OP_XOR: o = ra ? {5'b0, ^a} : rb ? {5'b0, ^b} : {3'b0, a ^ b};
        OP_ADD: o = 6'(a) + 6'(b) + 6'(f[F_CIN]);
        OP_MUL: o = 6'(a) * 6'(b);
        OP_SHIFT: o = f[F_DIR] ? {a[1:0], b, f[F_SERIAL]}
                               : {f[F_SERIAL], a, b[2:1]};
        default: o = f[F_DIR] ? {a[1:0], b, a[2]}
                              : {b[0], a, b[2:1]};
      endcase
    end
    return {e, o};
  endfunction

  // Two-register ALSU pipeline: sample edge + LATENCY to out
  logic [6:0] s1 = '0;
  logic [6:0] s2 = '0;
  always @(posedge clk) begin
    s1 <= alsu_f(alsu_a, alsu_b, alsu_opcode, alsu_flags);
    s2 <= s1;
  end
  assign alsu_out  = s2[5:0];
  assign alsu_leds = s2[6] ? 16'hFFFF : 16'h0000;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {15'b0, cmd_ready, alsu_a, alsu_b, alsu_opcode, alsu_flags,
            rsp_valid, rsp_out, rsp_err, done_count, err_count};
  endfunction

  // One full command: issue, timing, response, handshake
  task automatic do_cmd(input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] op, input logic [6:0] f,
                        input int stall, input int expo);
    logic [6:0] r;
    logic [5:0] eo;
    int n;
    r  = alsu_f(a, b, op, f);
    eo = (expo < 0) ? r[5:0] : expo[5:0];
    cmd_a = a; cmd_b = b; cmd_opcode = op; cmd_flags = f;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("drive_pulse", {42'b0, alsu_a, alsu_b, alsu_opcode, alsu_flags},
        {42'b0, a, b, op, f});
    chk("busy_not_ready", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    chk("parked", {48'b0, alsu_a, alsu_b, alsu_opcode, alsu_flags}, 64'd0);
    n = 1;
    while (!rsp_valid && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'(LAT + 1));
    chk("rsp_out", 64'(rsp_out), 64'(eo));
    chk("rsp_err", 64'(rsp_err), 64'(r[6]));
    for (int i = 0; i < stall; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_a = 3'($urandom);
      @(negedge clk);
      chk("stall_hold", {56'b0, rsp_valid, rsp_out, cmd_ready},
          {56'b0, 1'b1, eo, 1'b0});
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_done = (exp_done + 1) % 65536;
    if (r[6] && exp_err < 255) exp_err++;
    chk("rsp_cleared", 64'(rsp_valid), 64'd0);
    chk("done_count", 64'(done_count), 64'(exp_done));
    chk("err_count", 64'(err_count), 64'(exp_err));
    chk("ready_again", 64'(cmd_ready), 64'd1);
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_done = 0;
    exp_err = 0;
    @(negedge clk);
  endtask

  initial begin
    logic seen;
    rst = 1'b0;
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_opcode = '0; cmd_flags = '0;

    repeat (3) begin
      @(negedge clk);
      chk("reset_outs", all_outs(), 64'd0);
    end
    rst = 1'b1;
    #1 chk("ready_low_pre_edge", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    chk("ready_after_release", 64'(cmd_ready), 64'd1);

    do_cmd(3'd3, 3'd5, OP_ADD, 7'b1000000, 0, 9);
    do_cmd(3'd7, 3'd7, OP_MUL, 7'b0000000, 0, 49);
    do_cmd(3'd3, 3'd1, OP_XOR, 7'b0010000, 0, 0);
    do_cmd(3'd2, 3'd4, 3'd6, 7'b0000000, 0, 0);
    chk("first_err", 64'(err_count), 64'd1);
    do_cmd(3'd6, 3'd3, OP_AND, 7'b0000000, 5, 2);
    do_cmd(3'd5, 3'd2, OP_SHIFT, 7'b0100001, 2, -1);
    do_cmd(3'd5, 3'd2, OP_ROTATE, 7'b0000000, 1, -1);

    rst_pulse();
    for (int i = 0; i < 300; i++)
      do_cmd(3'($urandom), 3'($urandom), 3'($urandom_range(6, 7)),
             7'($urandom), 0, 0);
    chk("err_saturated", 64'(err_count), 64'd255);
    chk("done_300", 64'(done_count), 64'd300);

    @(negedge clk);
    cmd_a = 3'd4; cmd_b = 3'd1; cmd_opcode = OP_ADD; cmd_flags = '0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("async_reset_outs", all_outs(), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    exp_done = 0;
    exp_err = 0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    chk("lost_inflight", 64'(seen), 64'd0);
    do_cmd(3'd1, 3'd1, OP_ADD, 7'b0000000, 0, 2);

    for (int i = 0; i < 40; i++)
      do_cmd(3'($urandom), 3'($urandom), 3'($urandom_range(0, 7)),
             7'($urandom), $urandom_range(0, 3), -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/alsu_driver.md
# alsu_driver

Command-side initiator for the ALSU. Accepts one operation per valid/ready handshake, presents it to the ALSU input ports for exactly one cycle, waits out the ALSU pipeline latency, and captures `out` and `leds`. It then returns the result over a valid/ready response channel. It sits between a command source (CPU register block or test sequencer) and the ALSU, and keeps completion and error counters.

## Interface
- `LATENCY`, default 2: ALSU cycles from input sampling edge to registered `out`.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, asynchronous, active-low (0 = reset).
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: driver can accept. High only in IDLE.
- `cmd_a` in 3: operand A.
- `cmd_b` in 3: operand B.
- `cmd_opcode` in 3: ALSU opcode.
- `cmd_flags` in 7: packed {cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction}, bit 6 down to 0.
- `alsu_a`, `alsu_b`, `alsu_opcode` out 3 each: drive to ALSU.
- `alsu_flags` out 7: same packing as `cmd_flags`. Split at top level.
- `alsu_out` in 6: ALSU result.
- `alsu_leds` in 16: ALSU error indicator.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer takes result.
- `rsp_out` out 6: captured `alsu_out`.
- `rsp_err` out 1: captured `|alsu_leds`.
- `done_count` out 16: completed responses. Wraps.
- `err_count` out 8: responses with `rsp_err=1`. Saturates at 255.

## Operation
- FSM states: IDLE, DRIVE, WAIT, RESP.
- IDLE: `cmd_ready=1`. When `cmd_valid` is high at a rising edge (edge k), register the command onto the `alsu_*` outputs and go to DRIVE.
- DRIVE: lasts one cycle. At edge k+1 the ALSU samples the command. At that edge the `alsu_*` outputs return to all-zero (parked: opcode 0, flags 0, A=B=0), load the wait counter with `LATENCY`, and go to WAIT.
- The one-cycle pulse makes shift and rotate (opcodes 4 and 5) act exactly once per command.
- WAIT: decrement the counter each edge. At edge k+LATENCY+1, register `alsu_out` into `rsp_out` and `|alsu_leds` into `rsp_err`, set `rsp_valid`, and go to RESP.
- RESP: hold `rsp_valid`, `rsp_out` and `rsp_err` stable until `rsp_valid && rsp_ready` at an edge. On that edge:
  - clear `rsp_valid`;
  - increment `done_count`;
  - increment `err_count` if `rsp_err=1` and the count is below 255;
  - go to IDLE.
- `cmd_valid` outside IDLE is ignored; `cmd_ready=0` there. A new command can be accepted no earlier than the edge after the response handshake.
- The driver does not interpret opcodes. Invalid opcodes (6, 7) and bad red_op usage are reported only through `rsp_err`.

## Timing
- Reset values: all outputs 0; state IDLE. `cmd_ready` is 0 while `rst=0` and 1 from the first edge after release.
- Reset asserted mid-operation: clears state, counters, response registers and `alsu_*` immediately (asynchronously). Any in-flight command is lost with no response.
- Latency: `rsp_valid` rises after edge k+LATENCY+1, which is 3 cycles for the default. Minimum command period is LATENCY+3 cycles (IDLE, DRIVE, WAIT×LATENCY, RESP).
- Counter boundaries: `done_count` wraps 65535→0. `err_count` holds at 255.
- All outputs are registered.

## Structure
- Shared package `alsu_pkg` holds:
  - opcode constants: AND=0, XOR=1, ADD=2, MUL=3, SHIFT=4, ROTATE=5;
  - `cmd_flags` bit-index constants;
  - the FSM state encoding.
- Single module; no sub-module. The wait counter is `$clog2(LATENCY+1)` bits wide, inline.

## Test plan
Each scenario runs against the real ALSU with `LATENCY=2`.
- Reset and release: hold `rst=0` for 3 cycles, then set `rst=1` → all outputs 0 during reset, and `cmd_ready=1` one edge after release.
- ADD (A=3, B=5, cin=1, opcode=2) → `rsp_out=9`, `rsp_err=0`, `rsp_valid` high 3 cycles after acceptance; `alsu_opcode` is 2 for exactly one cycle.
- MUL (A=7, B=7, opcode=3) → `rsp_out=49`. Then XOR with red_op_A=1, A=3 → `rsp_out=0`.
- Invalid opcode 6 → `rsp_err=1`, `err_count=1`. After 300 such commands → `err_count=255`, `done_count=300`.
- Backpressure: hold `rsp_ready=0` for 5 cycles during RESP → `rsp_valid`, `rsp_out` stable; `cmd_ready=0`; `cmd_valid` pulses ignored.
- Set `rst=0` during WAIT → outputs zero immediately, no response. A following ADD (1, 1, cin=0) returns `rsp_out=2`.
